shift_register: RTL and testbench



---
 rtl/shift_register.sv | 31 +++
 tb/tb_shift_register.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// 8-bit shift register used as a byte serializer/deserializer: parallel load or
// MSB-first left shift each cycle, with both outputs taken straight from the register.
module shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_ser_in,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] sr_r;

    // Register update: load wins over shift; new serial bits enter at the LSB
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sr_r <= {WIDTH{1'b0}};
        end else if (i_load) begin
            sr_r <= i_par_in;
        end else begin
            sr_r <= {sr_r[WIDTH-2:0], i_ser_in};
        end
    end

    assign o_par_out = sr_r;
    assign o_ser_out = sr_r[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register: reset, SIPO, PISO, load
// priority, async reset and a short run of random bytes through both directions.
module tb_shift_register;

    logic       clk;
    logic       rstn;
    logic       load;
    logic       ser_in;
    logic [7:0] par_in;
    logic [7:0] par_out;
    logic       ser_out;

    int tests_run;
    int tests_failed;

    shift_register #(.WIDTH(8)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_load    (load),
        .i_ser_in  (ser_in),
        .i_par_in  (par_in),
        .o_par_out (par_out),
        .o_ser_out (ser_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1 time unit past it
    task automatic step(input logic l, input logic s, input logic [7:0] p);
        load   = l;
        ser_in = s;
        par_in = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] sipo_a5;
        logic [7:0] sipo_3c;
        tests_run    = 0;
        tests_failed = 0;
        sipo_a5 = 8'hA5;
        sipo_3c = 8'h3C;

        // Reset held with a pending load of 0xFF
        rstn   = 1'b0;
        load   = 1'b1;
        ser_in = 1'b1;
        par_in = 8'hFF;
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'hFF);
            chk8("reset_par", par_out, 8'h00);
            chk1("reset_ser", ser_out, 1'b0);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 1'b0, 8'hFF);
        chk8("first_load", par_out, 8'hFF);

        // SIPO: 0xA5 then 0x3C back-to-back, MSB first
        for (int i = 7; i >= 0; i--) step(1'b0, sipo_a5[i], 8'h00);
        chk8("sipo_a5", par_out, 8'hA5);
        for (int i = 7; i >= 0; i--) step(1'b0, sipo_3c[i], 8'hFF);
        chk8("sipo_3c", par_out, 8'h3C);

        // PISO: load 0xC3, serial out 1,1,0,0,0,0,1,1
        step(1'b1, 1'b1, 8'hC3);
        chk1("piso_b7", ser_out, 1'b1);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b6", ser_out, 1'b1);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b5", ser_out, 1'b0);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b4", ser_out, 1'b0);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b3", ser_out, 1'b0);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b2", ser_out, 1'b0);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b1", ser_out, 1'b1);
        step(1'b0, 1'b0, 8'hFF); chk1("piso_b0", ser_out, 1'b1);
        chk8("piso_mid", par_out, 8'h80);
        step(1'b0, 1'b0, 8'hFF);
        chk8("piso_drained", par_out, 8'h00);

        // Load aborts a partial shift; no residual bits survive
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        chk8("partial_shift", par_out, 8'h0F);
        step(1'b1, 1'b1, 8'h12);
        chk8("abort_load", par_out, 8'h12);
        step(1'b0, 1'b0, 8'h00);
        chk8("shift_after_load", par_out, 8'h24);

        // Consecutive loads: last one wins
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 8'h77);
        chk8("last_load_wins", par_out, 8'h77);

        // Async reset between edges while holding 0x5A
        step(1'b1, 1'b0, 8'h5A);
        chk8("pre_async", par_out, 8'h5A);
        #2 rstn = 1'b0;
        #1;
        chk8("async_reset_par", par_out, 8'h00);
        chk1("async_reset_ser", ser_out, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Random bytes through SIPO then PISO
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            for (int i = 7; i >= 0; i--) step(1'b0, b[i], ~b);
            chk8("rand_sipo", par_out, b);
            b = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, b);
            chk1("rand_piso_b7", ser_out, b[7]);
            for (int i = 6; i >= 0; i--) begin
                step(1'b0, 1'b1, ~b);
                chk1("rand_piso_bit", ser_out, b[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
